gcd_stein_core: RTL and testbench
=================================

# gcd_stein_core

Responder-side GCD engine for the `start`/`valid` compute handshake used by the multi-operand GCD sequencers. The sequencer pulses `start` with two operands, and this block returns `gcd(a_in, b_in)` with a one-cycle `valid` pulse. It uses the binary (Stein) algorithm, so the datapath needs only shift, subtract and compare, with no divider. It instantiates directly in place of the 16-bit GCD engine and adds a `busy` output.

## Interface
- `W`, default 16: operand and result width.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `a_in`  in  W: operand A; captured on an accepted `start`.
- `b_in`  in  W: operand B; captured on an accepted `start`.
- `busy`  out  1: high whenever state ≠ IDLE.
- `valid`  out  1: one-cycle result strobe.
- `out`  out  W: result; holds its value until the next result.

## Operation
- Registers: `a` (W bits), `b` (W bits), `k` (shift count, $clog2(W)+1 bits), `res` (W bits).
- IDLE: on `start`=1, capture `a`←`a_in`, `b`←`b_in`, `k`←0, then go to CHECK. Otherwise stay in IDLE.
- CHECK, one cycle:
  - if `a`==0: `res`=`b`, go to DONE.
  - else if `b`==0: `res`=`a`, go to DONE.
  - else go to FACTOR.
- FACTOR:
  - if `a` and `b` are both even: shift both right by 1, `k`++, stay.
  - otherwise (the deciding cycle, no shift): go to EVEN.
- EVEN, both registers evaluated in the same cycle:
  - if `a` is even, `a`>>=1.
  - if `b` is even, `b`>>=1.
  - when both are odd, go to SUB (no shift in that cycle).
- SUB:
  - if `a`==`b`: `res`=`a`<<`k`, go to DONE.
  - else if `a`>`b`: `a`=`a`−`b`; otherwise `b`=`b`−`a`.
  - after a subtract, go to EVEN.
- DONE: `valid`=1 and `out`=`res` are registered on entry. Leave for IDLE on the next edge.
- Arithmetic: unsigned throughout. Subtraction never underflows. `res`<<`k` never overflows W.
- gcd(0,0) returns 0.
- `start` is ignored while `busy`=1. Operand changes after capture have no effect.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, `busy`=0, `valid`=0, `out`=0, and all internal registers 0.
- A reset mid-operation aborts the computation, and no `valid` pulse follows.
- Latency is counted from the edge that samples `start`:
  - if either operand is 0, `valid` is high in the 2nd cycle after that edge.
  - otherwise `valid` is high no later than cycle 5W+4.
- `valid` is high for exactly one cycle. `out` changes only in that cycle.
- `busy` rises on the edge after `start` is accepted and falls on the edge leaving DONE.
- `start` asserted in the cycle `valid` is high is ignored; the block is not yet back in IDLE. The earliest accepted `start` is in the first IDLE cycle.

## Configuration
- `GCD_STEIN_CYCLE_CNT_EN` defined:
  - adds output `cycles` (out, 8 bits): the number of cycles from CHECK through SUB inclusive for the last result.
  - `cycles` is latched with `out`, saturates at 255, and resets to 0.
- `GCD_STEIN_CYCLE_CNT_EN` undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `gcd_pkg` holds:
  - the state enum (IDLE, CHECK, FACTOR, EVEN, SUB, DONE);
  - the default width constant `GCD_W`=16.
- Sub-module `gcd_stein_dp` holds the datapath: the `a`/`b`/`k` registers, shifters, subtractor, comparator and the parity/zero/equal flags.
- The top level holds the FSM, the `valid`/`out` registers and the optional counter.

## Test plan
- Reset mid-compute: start(48,18), deassert `rst_n` on cycle 3 → `busy`=0, `valid`=0, `out`=0 immediately. No `valid` pulse after release.
- Zero operands:
  - start(0,5) → `valid` in cycle 2, `out`=5.
  - start(7,0) → `out`=7.
  - start(0,0) → `out`=0.
- Common powers of two and general values:
  - start(48,18) → `out`=6.
  - start(12,18) → `out`=6.
  - start(1024,256) → `out`=256.
- Worst-case sizes: start(65535,1) → `out`=1; start(65534,32768) → `out`=2. Each `valid` is within 84 cycles of the sampling edge.
- Handshake:
  - pulse `start` with different operands while `busy` → ignored; the first result is unchanged.
  - `start` during the `valid` cycle → ignored.
  - `start` in the next cycle → accepted.
- Back-to-back runs: gcd(270,192)=6, then gcd(17,5)=1. Check that `out` holds 6 until the second `valid`, and that `valid` is a single cycle each time.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg
// Shared definitions for the binary (Stein) GCD engine:
//   GCD_W        default operand/result width
//   gcd_state_e  controller states
//   gcd_flags_t  datapath status flags consumed by the controller
//   sat_inc8     saturating 8-bit increment (cycle counter)
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_FACTOR = 3'd2,
    ST_EVEN   = 3'd3,
    ST_SUB    = 3'd4,
    ST_DONE   = 3'd5
  } gcd_state_e;

  typedef struct packed {
    logic a_zero;
    logic b_zero;
    logic a_even;
    logic b_even;
    logic a_eq_b;
    logic a_gt_b;
  } gcd_flags_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gcd_stein_dp.sv
// gcd_stein_dp
// Datapath of the Stein GCD engine: operand registers a/b, the common
// power-of-two count k, shifters, subtractor, comparator and status flags.
// Exactly one control strobe is expected per cycle; they are prioritised
// load > factor_shift > even_step > sub_step.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture a_in/b_in, clear k
//   factor_shift      both operands even: halve both, k++
//   even_step         halve whichever operand is even
//   sub_step          subtract the smaller operand from the larger
//   a_in, b_in        operands
//   flags             zero/parity/equal/greater flags of a and b
//   a_val, b_val      current register values
//   a_shl_k           a << k (final result once a == b)
module gcd_stein_dp
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         factor_shift,
  input  logic         even_step,
  input  logic         sub_step,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output gcd_flags_t   flags,
  output logic [W-1:0] a_val,
  output logic [W-1:0] b_val,
  output logic [W-1:0] a_shl_k
);

  localparam int KW = $clog2(W) + 1;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [KW-1:0] k_q;

  always_comb begin
    flags.a_zero = (a_q == '0);
    flags.b_zero = (b_q == '0);
    flags.a_even = ~a_q[0];
    flags.b_even = ~b_q[0];
    flags.a_eq_b = (a_q == b_q);
    flags.a_gt_b = (a_q > b_q);
  end

  assign a_val   = a_q;
  assign b_val   = b_q;
  assign a_shl_k = a_q << k_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      k_q <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
      k_q <= '0;
    end else if (factor_shift) begin
      a_q <= a_q >> 1;
      b_q <= b_q >> 1;
      k_q <= k_q + KW'(1);
    end else if (even_step) begin
      // Both halvings happen in the same cycle; an odd operand is left alone.
      if (!a_q[0]) a_q <= a_q >> 1;
      if (!b_q[0]) b_q <= b_q >> 1;
    end else if (sub_step) begin
      // Larger minus smaller, so the difference can never wrap.
      if (a_q > b_q)       a_q <= a_q - b_q;
      else if (a_q != b_q) b_q <= b_q - a_q;
    end
  end

endmodule

// File: rtl/gcd_stein_core.sv
// gcd_stein_core
// Binary (Stein) GCD engine answering the start/valid compute handshake.
// Handshake: start is sampled only while the engine is idle (busy == 0); a
// sampled start captures a_in/b_in, and start is ignored at all other times
// including the cycle valid is high. Exactly one valid pulse of one cycle
// follows each accepted start (unless reset intervenes); out is updated in
// that same cycle and holds until the next pulse.
// Optional feature macro: GCD_STEIN_CYCLE_CNT_EN adds the 8-bit 'cycles'
// output (cycles spent in CHECK..SUB for the last result, saturating).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request
//   a_in, b_in   operands
//   busy         high while not idle
//   valid        one-cycle result strobe
//   out          result
//   cycles       (macro only) compute cycle count of the last result
module gcd_stein_core
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] out
`ifdef GCD_STEIN_CYCLE_CNT_EN
  ,
  output logic [7:0]   cycles
`endif
);

  gcd_state_e   state_q, state_d;
  gcd_flags_t   flags;
  logic [W-1:0] a_val, b_val, a_shl_k;
  logic         load, factor_shift, even_step, sub_step;
  logic         done_set;
  logic [W-1:0] res_d;
  logic         valid_q;
  logic [W-1:0] out_q;

  gcd_stein_dp #(.W(W)) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .factor_shift (factor_shift),
    .even_step    (even_step),
    .sub_step     (sub_step),
    .a_in         (a_in),
    .b_in         (b_in),
    .flags        (flags),
    .a_val        (a_val),
    .b_val        (b_val),
    .a_shl_k      (a_shl_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    factor_shift = 1'b0;
    even_step    = 1'b0;
    sub_step     = 1'b0;
    done_set     = 1'b0;
    res_d        = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // gcd(0,x) = x covers gcd(0,0) = 0 as well.
        if (flags.a_zero) begin
          res_d    = b_val;
          done_set = 1'b1;
          state_d  = ST_DONE;
        end else if (flags.b_zero) begin
          res_d    = a_val;
          done_set = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_FACTOR;
        end
      end
      ST_FACTOR: begin
        if (flags.a_even && flags.b_even) factor_shift = 1'b1;
        else                              state_d = ST_EVEN;
      end
      ST_EVEN: begin
        if (flags.a_even || flags.b_even) even_step = 1'b1;
        else                              state_d = ST_SUB;
      end
      ST_SUB: begin
        if (flags.a_eq_b) begin
          res_d    = a_shl_k;
          done_set = 1'b1;
          state_d  = ST_DONE;
        end else begin
          sub_step = 1'b1;
          state_d  = ST_EVEN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // valid/out are registered on the edge entering DONE, so they are visible
  // exactly during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      valid_q <= done_set;
      if (done_set) out_q <= res_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign valid = valid_q;
  assign out   = out_q;

`ifdef GCD_STEIN_CYCLE_CNT_EN
  logic [7:0] run_cnt_q;
  logic [7:0] cycles_q;

  // run_cnt_q counts completed compute cycles; the cycle that finishes is
  // added when the result is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (state_q == ST_IDLE || state_q == ST_DONE) run_cnt_q <= '0;
      else                                          run_cnt_q <= sat_inc8(run_cnt_q);
      if (done_set) cycles_q <= sat_inc8(run_cnt_q);
    end
  end

  assign cycles = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_stein_core.sv
module tb_gcd_stein_core;
  import gcd_pkg::*;

  localparam int W = GCD_W;
  localparam int MAX_LAT = 5 * W + 4;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         valid;
  logic [W-1:0] out;
`ifdef GCD_STEIN_CYCLE_CNT_EN
  logic [7:0]   cycles;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  gcd_stein_core #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .valid (valid),
    .out   (out)
`ifdef GCD_STEIN_CYCLE_CNT_EN
    ,
    .cycles(cycles)
`endif
  );

  // ---------------- reference model (Euclid, plain arithmetic) ----------------
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // ---------------- driver ----------------
  // Issues one request, scrambles the operand inputs after capture, waits for
  // valid (bounded), and reports latency from the sampling edge (-1 = timeout),
  // whether out held hold_val while waiting, and whether valid dropped after one cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic hold_chk, input logic [W-1:0] hold_val,
                        output logic [W-1:0] got, output int lat,
                        output logic hold_ok, output logic single);
    hold_ok = 1'b1;
    lat     = -1;
    single  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    exp_q.push_back(ref_gcd(a, b));
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) @(negedge clk);
      if (valid === 1'b1) begin
        lat = n;
        break;
      end
      if (hold_chk && out !== hold_val) hold_ok = 1'b0;
    end
    got = out;
    @(negedge clk);
    single = (valid === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if (busy !== 1'b0 || valid !== 1'b0 || out !== '0) begin
      $display("FAIL reset_state: busy=%b valid=%b out=%0d, want 0/0/0", busy, valid, out);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      $display("FAIL reset_idle: busy=%b valid=%b, want 0/0", busy, valid);
    end else pass_cnt++;
  endtask

  task automatic test_zero_operands();
    logic [W-1:0] ta[3] = '{16'd0, 16'd7, 16'd0};
    logic [W-1:0] tb[3] = '{16'd5, 16'd0, 16'd0};
    logic [W-1:0] got, exp;
    int lat;
    logic hold_ok, single;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], 1'b0, '0, got, lat, hold_ok, single);
      exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL zero_out(%0d,%0d): got %0d want %0d", ta[i], tb[i], got, exp);
      else pass_cnt++;
      total_cnt++;
      if (lat != 2) $display("FAIL zero_latency(%0d,%0d): got %0d want 2", ta[i], tb[i], lat);
      else pass_cnt++;
      total_cnt++;
      if (!single) $display("FAIL zero_single_valid(%0d,%0d): valid still high", ta[i], tb[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{16'd48, 16'd12, 16'd1024, 16'd65535, 16'd65534};
    logic [W-1:0] tb[5] = '{16'd18, 16'd18, 16'd256,  16'd1,     16'd32768};
    logic [W-1:0] got, exp;
    int lat;
    logic hold_ok, single;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], 1'b0, '0, got, lat, hold_ok, single);
      exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp) $display("FAIL directed_out(%0d,%0d): got %0d want %0d", ta[i], tb[i], got, exp);
      else pass_cnt++;
      total_cnt++;
      if (lat < 1 || lat > MAX_LAT)
        $display("FAIL directed_latency(%0d,%0d): got %0d want 1..%0d", ta[i], tb[i], lat, MAX_LAT);
      else pass_cnt++;
      total_cnt++;
      if (!single) $display("FAIL directed_single_valid(%0d,%0d): valid still high", ta[i], tb[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, got, exp;
    int lat;
    logic hold_ok, single;
    for (int i = 0; i < 30; i++) begin
      // Shifting left by a shared amount forces common powers of two.
      a = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      b = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      if (i % 3 == 0) begin
        int s = $urandom_range(1, 6);
        a = a << s;
        b = b << s;
      end
      run_op(a, b, 1'b0, '0, got, lat, hold_ok, single);
      exp = exp_q.pop_front();
      total_cnt++;
      if (got !== exp || lat < 1 || lat > MAX_LAT || !single)
        $display("FAIL random(%0d,%0d): out %0d want %0d, latency %0d want 1..%0d, single=%b want 1",
                 a, b, got, exp, lat, MAX_LAT, single);
      else pass_cnt++;
    end
  endtask

  task automatic test_handshake();
    int lat;
    // Start (48,18); mid-compute start with other operands must be ignored.
    @(negedge clk);
    start = 1'b1; a_in = 16'd48; b_in = 16'd18;
    exp_q.push_back(ref_gcd(16'd48, 16'd18));
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL hs_busy_rise: got %b want 1", busy);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1; a_in = 16'd7; b_in = 16'd3;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 3; n <= 200; n++) begin
      if (valid === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (lat < 0 || out !== exp_q[0]) $display("FAIL hs_busy_ignore: out %0d want %0d (latency %0d)", out, exp_q[0], lat);
    else pass_cnt++;
    void'(exp_q.pop_front());
    // In the valid cycle: start with (100,75) must be ignored.
    start = 1'b1; a_in = 16'd100; b_in = 16'd75;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL hs_back_to_idle: busy=%b valid=%b want 0/0", busy, valid);
    else pass_cnt++;
    // First IDLE cycle: start with (9,6) must be accepted.
    a_in = 16'd9; b_in = 16'd6;
    exp_q.push_back(ref_gcd(16'd9, 16'd6));
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL hs_accept_next: busy=%b want 1", busy);
    else pass_cnt++;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (valid === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (lat < 0 || out !== exp_q[0]) $display("FAIL hs_accept_result: out %0d want %0d (latency %0d)", out, exp_q[0], lat);
    else pass_cnt++;
    void'(exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got1, got2, exp1, exp2;
    int lat1, lat2;
    logic h1, h2, s1, s2;
    run_op(16'd270, 16'd192, 1'b0, '0, got1, lat1, h1, s1);
    exp1 = exp_q.pop_front();
    run_op(16'd17, 16'd5, 1'b1, exp1, got2, lat2, h2, s2);
    exp2 = exp_q.pop_front();
    total_cnt++;
    if (got1 !== exp1 || !s1) $display("FAIL b2b_first: out %0d want %0d, single=%b want 1", got1, exp1, s1);
    else pass_cnt++;
    total_cnt++;
    if (!h2) $display("FAIL b2b_hold: out left %0d before second valid", exp1);
    else pass_cnt++;
    total_cnt++;
    if (got2 !== exp2 || !s2 || lat2 < 1) $display("FAIL b2b_second: out %0d want %0d, single=%b want 1, latency %0d", got2, exp2, s2, lat2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got, exp;
    int lat;
    int seen;
    logic hold_ok, single;
    @(negedge clk);
    start = 1'b1; a_in = 16'd48; b_in = 16'd18;
    @(negedge clk);            // cycle 1 after sampling edge
    start = 1'b0;
    @(negedge clk);            // cycle 2
    @(negedge clk);            // cycle 3
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || valid !== 1'b0 || out !== '0)
      $display("FAIL reset_mid_immediate: busy=%b valid=%b out=%0d want 0/0/0", busy, valid, out);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) seen++;
    end
    total_cnt++;
    if (seen != 0) $display("FAIL reset_mid_no_valid: %0d active cycles after release, want 0", seen);
    else pass_cnt++;
    run_op(16'd12, 16'd18, 1'b0, '0, got, lat, hold_ok, single);
    exp = exp_q.pop_front();
    total_cnt++;
    if (got !== exp) $display("FAIL reset_mid_recover: out %0d want %0d", got, exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_operands();
    test_directed();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
